// File: rtl/picosoc_uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions, FSM encodings, divisor floor.
// Intended to be reused by a future picosoc_uart_rx.
package picosoc_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STS_BUSY    = 0;
  localparam int STS_FULL    = 1;
  localparam int STS_EMPTY   = 2;
  localparam int STS_LVL_LSB = 4;
  localparam int STS_OVF     = 8;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/picosoc_sync_fifo.sv
// Single-clock FIFO; pop-before-push on a full FIFO, pop ignored when empty.
module picosoc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/picosoc_uart_tx.sv
// Memory-mapped UART transmitter: register decode, TX FIFO, baud/bit counters, serialiser FSM.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd via CTRL[1]).
import picosoc_uart_pkg::*;

module picosoc_uart_tx #(
  parameter int CLK_DIV_RST = 868,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_sel,
  input  logic [3:0]  reg_wstrb,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ready,
  output logic        uart_txd,
  output logic        tx_irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state;
  logic [15:0] div, cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        irq_en, ovf;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd, par;
`endif

  logic          fifo_full, fifo_empty, push, pop, busy, bit_end;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level;
  logic [31:0]   lvl32, rd_val;
  logic [1:0]    ridx;
  logic          wr, rd;
  logic          unused_bits;

  assign ridx    = reg_addr[3:2];
  // Inputs are still held during the ready cycle, so side effects use them live.
  assign wr      = reg_ready && (reg_wstrb != 4'd0);
  assign rd      = reg_ready && (reg_wstrb == 4'd0);
  assign push    = wr && (ridx == REG_DATA) && reg_wstrb[0];
  assign busy    = (state != S_IDLE);
  assign bit_end = (cnt == 16'd0);
  assign pop     = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
  assign tx_irq  = irq_en && fifo_empty;
  assign lvl32   = 32'(fifo_level);

  assign unused_bits = ^{reg_addr[1:0], reg_wdata[31:16], lvl32[31:4]};

  picosoc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (reg_wdata[7:0]),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    rd_val = '0;
    case (ridx)
      REG_STATUS: begin
        rd_val[STS_BUSY]              = busy;
        rd_val[STS_FULL]              = fifo_full;
        rd_val[STS_EMPTY]             = fifo_empty;
        rd_val[STS_LVL_LSB +: 4]      = lvl32[3:0];
        rd_val[STS_OVF]               = ovf;
      end
      REG_DIV:  rd_val[15:0] = div;
      REG_CTRL: begin
        rd_val[0] = irq_en;
`ifdef UART_TX_PARITY_EN
        rd_val[1] = parity_odd;
`endif
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_ready  <= 1'b0;
      reg_rdata  <= '0;
      div        <= 16'(CLK_DIV_RST);
      irq_en     <= 1'b0;
      ovf        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_odd <= 1'b0;
`endif
    end else begin
      reg_ready <= reg_sel && !reg_ready;
      reg_rdata <= (reg_sel && !reg_ready && reg_wstrb == 4'd0) ? rd_val : '0;
      if (wr && ridx == REG_DIV)
        div <= clamp_div({reg_wstrb[1] ? reg_wdata[15:8] : div[15:8],
                          reg_wstrb[0] ? reg_wdata[7:0]  : div[7:0]});
      if (wr && ridx == REG_CTRL && reg_wstrb[0]) begin
        irq_en     <= reg_wdata[0];
`ifdef UART_TX_PARITY_EN
        parity_odd <= reg_wdata[1];
`endif
      end
      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      else if (rd && ridx == REG_STATUS)
        ovf <= 1'b0;
    end
  end

  // Bit counter reloads from div only at a bit boundary, so DIV writes never split a bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state    <= S_START;
            uart_txd <= 1'b0;
            shreg    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            par      <= ^fifo_dout;
`endif
            cnt      <= div - 16'd1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            uart_txd <= shreg[0];
            bitn     <= 3'd0;
            cnt      <= div - 16'd1;
          end else cnt <= cnt - 16'd1;
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= div - 16'd1;
            if (bitn == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= S_PARITY;
              uart_txd <= par ^ parity_odd;
`else
              state    <= S_STOP;
              uart_txd <= 1'b1;
`endif
            end else begin
              bitn     <= bitn + 3'd1;
              shreg    <= shreg >> 1;
              uart_txd <= shreg[1];
            end
          end else cnt <= cnt - 16'd1;
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            uart_txd <= 1'b1;
            cnt      <= div - 16'd1;
          end else cnt <= cnt - 16'd1;
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              state    <= S_START;
              uart_txd <= 1'b0;
              shreg    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
              par      <= ^fifo_dout;
`endif
              cnt      <= div - 16'd1;
            end else begin
              state    <= S_IDLE;
              uart_txd <= 1'b1;
            end
          end else cnt <= cnt - 16'd1;
        end
        default: begin
          state    <= S_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_uart_tx.sv
// Directed bench for picosoc_uart_tx: register map, frame timing, back-to-back, overflow, IRQ, async reset.
module tb_picosoc_uart_tx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_sel;
  logic [3:0]  reg_wstrb;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        uart_txd;
  logic        tx_irq;

  int total = 0;
  int bad   = 0;
  int lat_last;
  logic [31:0] rv;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  picosoc_uart_tx #(.CLK_DIV_RST(868), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reg_sel   (reg_sel),
    .reg_wstrb (reg_wstrb),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready),
    .uart_txd  (uart_txd),
    .tx_irq    (tx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic [3:0] a, input logic [3:0] strb, input logic [31:0] d,
                          output logic [31:0] q);
    bit seen;
    seen = 1'b0;
    q = '0;
    lat_last = 0;
    reg_sel = 1'b1; reg_addr = a; reg_wstrb = strb; reg_wdata = d;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      lat_last++;
      if (reg_ready) begin seen = 1'b1; q = reg_rdata; end
    end
    if (!seen) chk("ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    reg_sel = 1'b0; reg_wstrb = 4'd0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(a, 4'hF, d, q);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] q);
    bus_xfer(a, 4'h0, 32'd0, q);
  endtask

  task automatic wait_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (uart_txd === 1'b0) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  // Called in the first cycle of the start bit; each slot must hold its level for exactly dv clks.
  task automatic run_frame(input logic [7:0] b, input int dv, input logic pb);
    logic [10:0] exp_bits;
    int m;
    exp_bits = (NB == 11) ? {1'b1, pb, b, 1'b0} : {2'b11, b, 1'b0};
    for (int s = 0; s < NB; s++) begin
      m = 0;
      for (int c = 0; c < dv; c++) begin
        if (uart_txd === exp_bits[s]) m++;
        @(posedge clk); #1;
      end
      chk($sformatf("frame %02h slot%0d", b, s), m, dv);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reg_sel = 1'b0; reg_wstrb = 4'd0; reg_addr = 4'd0; reg_wdata = '0;
    do_reset();

    // Reset state
    chk("rst txd", uart_txd, 1);
    chk("rst irq", tx_irq, 0);
    chk("rst ready", reg_ready, 0);
    chk("rst rdata", reg_rdata, 0);
    bus_rd(4'h4, rv); chk("rst status", rv, 32'h004);
    chk("ready latency", lat_last, 1);
    bus_rd(4'h8, rv); chk("rst div", rv, 868);
    bus_rd(4'hC, rv); chk("rst ctrl", rv, 0);
    bus_rd(4'h0, rv); chk("data reads 0", rv, 0);

    // DIV clamp and read-back
    bus_wr(4'h8, 0); bus_rd(4'h8, rv); chk("div clamp 0", rv, 2);
    bus_wr(4'h8, 1); bus_rd(4'h8, rv); chk("div clamp 1", rv, 2);
    bus_wr(4'h8, 32'hABCD0004); bus_rd(4'h8, rv); chk("div 4", rv, 4);

`ifndef UART_TX_PARITY_EN
    bus_wr(4'hC, 3); bus_rd(4'hC, rv); chk("ctrl bit1 ignored", rv, 1);
    bus_wr(4'hC, 0);
`endif

    // Single frame, with latency from the ready cycle
    bus_wr(4'h0, 32'h55);
    chk("lat +1 txd", uart_txd, 1);
    @(posedge clk); #1;
    chk("lat +2 txd", uart_txd, 0);
    run_frame(8'h55, 4, ^8'h55);
    chk("idle after 55", uart_txd, 1);
    bus_rd(4'h4, rv); chk("status after 55", rv, 32'h004);

    // Three contiguous frames
    fork
      begin
        bus_wr(4'h0, 32'hA1);
        bus_wr(4'h0, 32'hB2);
        bus_wr(4'h0, 32'hC3);
      end
      begin
        wait_start("b2b start");
        run_frame(8'hA1, 4, ^8'hA1);
        run_frame(8'hB2, 4, ^8'hB2);
        run_frame(8'hC3, 4, ^8'hC3);
      end
    join
    bus_rd(4'h4, rv); chk("status after b2b", rv, 32'h004);

    // Overflow: one byte in the shifter, eight in the FIFO, tenth dropped
    bus_wr(4'h8, 100);
    for (int i = 0; i < 10; i++) bus_wr(4'h0, i);
    bus_rd(4'h4, rv); chk("status overflow", rv, 32'h183);
    bus_rd(4'h4, rv); chk("overflow cleared", rv, 32'h083);

    // IRQ and async reset mid-frame
    do_reset();
    chk("flush txd", uart_txd, 1);
    bus_wr(4'h8, 4);
    bus_wr(4'hC, 1);
    chk("irq empty", tx_irq, 1);
    bus_wr(4'h0, 32'h00);
    chk("irq drops", tx_irq, 0);
    @(posedge clk); #1;
    chk("irq rises on pop", tx_irq, 1);
    chk("start bit", uart_txd, 0);
    repeat (10) @(posedge clk);
    #1 chk("mid frame low", uart_txd, 0);
    #2 reset_n = 1'b0;
    #1 chk("async txd", uart_txd, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    begin
      int m;
      m = 0;
      for (int i = 0; i < 20; i++) begin
        if (uart_txd === 1'b1) m++;
        @(posedge clk); #1;
      end
      chk("no resume", m, 20);
    end
    chk("irq after reset", tx_irq, 0);
    bus_rd(4'h4, rv); chk("status after reset", rv, 32'h004);

`ifdef UART_TX_PARITY_EN
    bus_wr(4'h8, 4);
    bus_wr(4'hC, 0);
    bus_wr(4'h0, 32'h07);
    wait_start("even start");
    run_frame(8'h07, 4, 1'b1);
    bus_rd(4'h4, rv); chk("status after even", rv, 32'h004);
    bus_wr(4'hC, 2);
    bus_rd(4'hC, rv); chk("ctrl odd", rv, 2);
    bus_wr(4'h0, 32'h07);
    wait_start("odd start");
    run_frame(8'h07, 4, 1'b0);
    bus_rd(4'h4, rv); chk("status after odd", rv, 32'h004);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
